// File: rtl/wb_pwm_meas.sv
`default_nettype none
// ============================================================================
// Module      : wb_pwm_meas
// Description : Eight-channel PWM duty-cycle meter. Counts synchronised high
//               cycles of each input over a 2^WIN_BITS-cycle window and
//               latches one result per channel. Pipelined Wishbone slave
//               register interface with RES, STATUS and CTRL registers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pwm_meas #(
  parameter int WIN_BITS = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic [7:0]  pwm_in
);

  localparam int                  NCH        = 8;
  localparam int                  RW         = WIN_BITS + 1;
  localparam logic [WIN_BITS-1:0] WIN_LAST   = '1;
  localparam logic [2:0]          ADR_STATUS = 3'd4;
  localparam logic [2:0]          ADR_CTRL   = 3'd5;

  // Registered state
  logic [7:0]          sync1_q, sync1_d;
  logic [7:0]          sync2_q, sync2_d;
  logic                en_q, en_d;
  logic [WIN_BITS-1:0] win_cnt_q, win_cnt_d;
  logic [RW-1:0]       hc_q  [NCH];
  logic [RW-1:0]       hc_d  [NCH];
  logic [RW-1:0]       res_q [NCH];
  logic [RW-1:0]       res_d [NCH];
  logic [7:0]          valid_q, valid_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;

  // Combinational decode
  logic                accept;
  logic                ctrl_wr;
  logic                stat_wr;
  logic                restart;
  logic                win_end;
  logic [7:0]          clr_valid;
  logic [7:0]          clr_ovr;
  logic [31:0]         rd_data;
  logic                unused_bits;

  // Address/data bits outside the decoded fields are intentionally ignored.
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;

  // Two results share one 32-bit word: even channel low half, odd channel high half.
  function automatic logic [31:0] pack_pair(input logic [RW-1:0] lo, input logic [RW-1:0] hi);
    logic [31:0] w;
    w = '0;
    w[RW-1:0]    = lo;
    w[16 +: RW]  = hi;
    return w;
  endfunction

  // Read multiplexer over the register map; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (!wb_adr_i[4]) begin
      rd_data = pack_pair(res_q[{wb_adr_i[3:2], 1'b0}], res_q[{wb_adr_i[3:2], 1'b1}]);
    end else begin
      case (wb_adr_i[4:2])
        ADR_STATUS: rd_data[15:0] = {ovr_q, valid_q};
        ADR_CTRL:   rd_data[0]    = en_q;
        default:    rd_data       = '0;
      endcase
    end
  end

  // Next-state logic for bus, synchronisers, window counter, channels and status.
  always_comb begin
    accept    = wb_cyc_i & wb_stb_i;
    ctrl_wr   = accept & wb_we_i & (wb_adr_i[4:2] == ADR_CTRL) & wb_sel_i[0];
    stat_wr   = accept & wb_we_i & (wb_adr_i[4:2] == ADR_STATUS);
    restart   = ctrl_wr & wb_dat_i[1];
    win_end   = en_q & (win_cnt_q == WIN_LAST);
    clr_valid = (stat_wr & wb_sel_i[0]) ? wb_dat_i[7:0]  : 8'h00;
    clr_ovr   = (stat_wr & wb_sel_i[1]) ? wb_dat_i[15:8] : 8'h00;

    ack_d   = accept;
    dat_d   = (accept & ~wb_we_i) ? rd_data : 32'h0;

    sync1_d = pwm_in;
    sync2_d = sync1_q;

    en_d    = ctrl_wr ? wb_dat_i[0] : en_q;

    // A disabled meter or a restart discards the partial window.
    if (!en_q || restart) begin
      win_cnt_d = '0;
    end else begin
      win_cnt_d = win_cnt_q + 1'b1;
    end

    for (int n = 0; n < NCH; n++) begin
      res_d[n] = win_end ? (hc_q[n] + RW'(sync2_q[n])) : res_q[n];
      if (!en_q || restart || win_end) begin
        hc_d[n] = '0;
      end else begin
        hc_d[n] = hc_q[n] + RW'(sync2_q[n]);
      end
    end

    // Window-end set takes priority over a simultaneous write-1-to-clear.
    valid_d = valid_q & ~clr_valid;
    ovr_d   = ovr_q & ~clr_ovr;
    if (win_end) begin
      valid_d = 8'hFF;
      ovr_d   = (ovr_q & ~clr_ovr) | valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      en_q      <= 1'b0;
      win_cnt_q <= '0;
      valid_q   <= '0;
      ovr_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      for (int n = 0; n < NCH; n++) begin
        hc_q[n]  <= '0;
        res_q[n] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      en_q      <= en_d;
      win_cnt_q <= win_cnt_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      for (int n = 0; n < NCH; n++) begin
        hc_q[n]  <= hc_d[n];
        res_q[n] <= res_d[n];
      end
    end
  end

endmodule
`default_nettype wire
